memory_arbiter: RTL

//  Shares the single RAM port between the instruction and data caches of CPUS cores.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_rr_picker.sv | 28 ++
 rtl/memory_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word, RAM handshake state and arbiter encodings.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arbsrc_t;

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin picker: first requesting core at or above the pointer, wrapping.
module mem_rr_picker #(
  parameter int unsigned CPUS  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [CPUS-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_win,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;

  // Scan from the farthest offset down so the closest requester to the pointer wins last.
  always_comb begin
    w_idx   = '0;
    o_win   = '0;
    o_valid = 1'b0;
    for (int i = int'(CPUS) - 1; i >= 0; i--) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % int'(CPUS));
      if (i_req[w_idx]) begin
        o_win   = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port among the I- and D-ports of CPUS cores; D beats I within a core,
// cores are served round-robin.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned RR_INIT = 0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  logic [31:0]           ramload,
  input  ramstate_t             ramstate,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  output logic                  ramREN,
  output logic                  ramWEN
);

  localparam int unsigned PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t       r_state, w_state_n;
  logic [PTR_W-1:0] r_rr, w_rr_n;
  logic [PTR_W-1:0] r_core, w_core_n;
  arbsrc_t          r_src, w_src_n;

  logic [CPUS-1:0]  w_req;
  logic [PTR_W-1:0] w_win;
  logic             w_valid;
  logic             w_live;

  assign w_req = iREN | dREN | dWEN;

  mem_rr_picker #(
    .CPUS  (CPUS),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // Load data is broadcast; only the core whose wait drops consumes it.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_rr    <= PTR_W'(RR_INIT);
      r_core  <= '0;
      r_src   <= SRC_I;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_core  <= w_core_n;
      r_src   <= w_src_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr;
    w_core_n  = r_core;
    w_src_n   = r_src;
    w_live    = 1'b0;
    iwait     = '1;
    dwait     = '1;
    ramaddr   = '0;
    ramstore  = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_core_n  = w_win;
          w_src_n   = (dREN[w_win] | dWEN[w_win]) ? SRC_D : SRC_I;
          w_state_n = SERVE;
        end
      end
      SERVE: begin
        w_live = (r_src == SRC_D) ? (dREN[r_core] | dWEN[r_core]) : iREN[r_core];
        // A dropped request is a flush: abandon without completing or advancing the pointer.
        if (!w_live) begin
          w_state_n = IDLE;
        end else begin
          if (r_src == SRC_D) begin
            ramaddr = daddr[r_core];
            if (dWEN[r_core]) begin
              ramWEN   = 1'b1;
              ramstore = dstore[r_core];
            end else begin
              ramREN = 1'b1;
            end
          end else begin
            ramaddr = iaddr[r_core];
            ramREN  = 1'b1;
          end
          case (ramstate)
            ACCESS: begin
              if (r_src == SRC_D) dwait[r_core] = 1'b0;
              else                iwait[r_core] = 1'b0;
              w_rr_n    = (r_core == PTR_W'(CPUS - 1)) ? '0 : r_core + PTR_W'(1);
              w_state_n = IDLE;
            end
            ERROR:   w_state_n = IDLE;
            default: w_state_n = SERVE;
          endcase
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule
